mem_access: RTL

// - MEM stage directly downstream of the EX ALU. Registers the ALU's interconnection_struct.
// - Performs data-memory loads and stores over a req/gnt/rvalid bus.
//   - Loads: aligns, sizes and sign/zero-extends the returned data into rf_wr_data.
//   - Stores: drives byte enables and shifted write data.
// - Stalls upstream while a memory transaction is outstanding, then forwards the struct to writeback.

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_access.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_pkg.sv
// Shared widths and the EX -> MEM -> WB interconnection payload.
package mem_access_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned BE_W = XLEN / 8;

  typedef struct packed {
    logic            is_valid;
    logic            rf_we;
    logic [4:0]      rd_addr;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] rf_wr_data;
  } interconnection_struct;

endpackage

// File: rtl/mem_access.sv
// MEM stage: registers the EX payload and runs data-memory loads/stores over req/gnt/rvalid.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  interconnection_struct i_struct,
  input  logic                  i_stall_dn,
  output interconnection_struct o_struct,
  output logic                  o_stall_up,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [BE_W-1:0]       dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  o_misalign
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;

  logic [1:0]            state_q, state_d;
  interconnection_struct cap_q, cap_d;
  interconnection_struct out_q, out_d;
  logic                  pend_q, pend_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  misalign_q, misalign_d;

  logic [2:0]            off_c;
  logic [3:0]            nbytes_c;
  logic [BE_W-1:0]       be_c;
  logic                  is_mem_c, misal_c, accept_c, done_c;
  interconnection_struct res_c;

  // Size/sign extraction of the returned doubleword lane
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [2:0] off,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [XLEN-1:0] raw;
    raw = rdata >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? XLEN'(raw[7:0])  : {{(XLEN-8){raw[7]}}, raw[7:0]};
      2'd1:    load_ext = uns ? XLEN'(raw[15:0]) : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'd2:    load_ext = uns ? XLEN'(raw[31:0]) : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  endfunction

  assign off_c    = i_struct.mem_addr[2:0];
  assign nbytes_c = 4'd1 << i_struct.mem_size;
  assign be_c     = BE_W'((16'd1 << nbytes_c) - 16'd1) << off_c;
  assign is_mem_c = i_struct.is_valid & (i_struct.mem_rd | i_struct.mem_wr);

`ifdef MEM_MISALIGN_CHK_EN
  assign misal_c = is_mem_c & ((off_c & 3'(nbytes_c - 4'd1)) != 3'd0);
`else
  assign misal_c = 1'b0;
`endif

  // A pending (stalled) result must drain before a new op is taken
  assign accept_c = (state_q == S_IDLE) & ~pend_q & ~i_stall_dn & is_mem_c & ~misal_c;
  assign done_c   = ((state_q == S_REQ) & dmem_gnt & cap_q.mem_wr) |
                    ((state_q == S_WAIT_R) & dmem_rvalid);

  // The completion cycle releases EX so the finished op is not re-issued
  assign o_stall_up = ((state_q != S_IDLE) & ~done_c) | i_stall_dn | accept_c;

  always_comb begin
    res_c          = cap_q;
    res_c.is_valid = 1'b1;
    if (state_q == S_WAIT_R) begin
      res_c.rf_wr_data = load_ext(dmem_rdata, cap_q.mem_addr[2:0], cap_q.mem_size,
                                  cap_q.mem_unsigned);
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    out_d      = out_q;
    pend_d     = pend_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_stall_dn) begin
          if (pend_q) begin
            out_d  = cap_q;
            pend_d = 1'b0;
          end else if (accept_c) begin
            cap_d          = i_struct;
            out_d.is_valid = 1'b0;
            req_d          = 1'b1;
            we_d           = i_struct.mem_wr;
            addr_d         = {i_struct.mem_addr[XLEN-1:3], 3'b000};
            wdata_d        = i_struct.mem_data << {off_c, 3'b000};
            be_d           = be_c;
            state_d        = S_REQ;
          end else if (misal_c) begin
            out_d            = i_struct;
            out_d.rf_wr_data = '0;
            misalign_d       = 1'b1;
          end else begin
            out_d = i_struct;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = cap_q.mem_wr ? S_IDLE : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (dmem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Under downstream stall the result is parked in cap and forwarded later
    if (done_c) begin
      if (i_stall_dn) begin
        cap_d  = res_c;
        pend_d = 1'b1;
      end else begin
        out_d = res_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      out_q      <= '0;
      pend_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_struct   = out_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign o_misalign = misalign_q;

endmodule
